// File: rtl/bcd_display_mux.sv
// Time-multiplexed 3-digit common-anode 7-segment driver fed by a 12-bit BCD word.
// Define BCD_DISPLAY_MUX_LZB_EN to blank leading zeros on the tens and hundreds digits.
module bcd_display_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_W       = 16,
    parameter int BLANK_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_in,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        frame_done
);

    localparam logic [1:0] DIG_UNITS    = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       dig_sel_q, dig_sel_d;
    logic [11:0]      shadow_q, shadow_d;
    logic [6:0]       seg_q, seg_d;
    logic [2:0]       an_q, an_d;
    logic             frame_done_q, frame_done_d;

    logic tick;
    logic capture;
    logic in_gap;
    logic lz_blank;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign tick    = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));
    assign capture = tick && (dig_sel_q == DIG_HUNDREDS);

    // With no gap configured the comparison would be constant-false, so it is elided.
    generate
        if (BLANK_CYC == 0) begin : g_no_gap
            assign in_gap = 1'b0;
        end else begin : g_gap
            assign in_gap = (div_cnt_q < DIV_W'(BLANK_CYC));
        end
    endgenerate

`ifdef BCD_DISPLAY_MUX_LZB_EN
    assign lz_blank = ((dig_sel_q == DIG_HUNDREDS) && (shadow_q[11:8] == 4'h0)) ||
                      ((dig_sel_q == DIG_TENS)     && (shadow_q[11:4] == 8'h00));
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        div_cnt_d    = tick ? '0 : div_cnt_q + DIV_W'(1);
        shadow_d     = capture ? bcd_in : shadow_q;
        frame_done_d = capture;
        dig_sel_d    = DIG_UNITS;
        case (dig_sel_q)
            DIG_UNITS:    dig_sel_d = tick ? DIG_TENS     : DIG_UNITS;
            DIG_TENS:     dig_sel_d = tick ? DIG_HUNDREDS : DIG_TENS;
            DIG_HUNDREDS: dig_sel_d = tick ? DIG_UNITS    : DIG_HUNDREDS;
            default:      dig_sel_d = DIG_UNITS;
        endcase
    end

    // Outputs are registered from the current slot state, so they trail div_cnt by one cycle.
    always_comb begin
        an_d  = 3'b111;
        seg_d = 7'h7F;
        if (!in_gap && !lz_blank) begin
            case (dig_sel_q)
                DIG_UNITS: begin
                    an_d  = 3'b110;
                    seg_d = decode(shadow_q[3:0]);
                end
                DIG_TENS: begin
                    an_d  = 3'b101;
                    seg_d = decode(shadow_q[7:4]);
                end
                DIG_HUNDREDS: begin
                    an_d  = 3'b011;
                    seg_d = decode(shadow_q[11:8]);
                end
                default: begin
                    an_d  = 3'b111;
                    seg_d = 7'h7F;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q    <= '0;
            dig_sel_q    <= DIG_UNITS;
            shadow_q     <= 12'h000;
            seg_q        <= 7'h7F;
            an_q         <= 3'b111;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            dig_sel_q    <= dig_sel_d;
            shadow_q     <= shadow_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux: a slow-scan instance (8-cycle slots, 2-cycle gap)
// and a fast instance (2-cycle slots, no gap) share clock, reset and bcd_in.
module tb_bcd_display_mux;

`ifdef BCD_DISPLAY_MUX_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [11:0] bcd_in;
    logic [6:0]  seg_a, seg_b;
    logic [2:0]  an_a, an_b;
    logic        fd_a, fd_b;

    int checks = 0;
    int errors = 0;

    bcd_display_mux #(.REFRESH_DIV(8), .DIV_W(4), .BLANK_CYC(2)) dut_a (
        .clk(clk), .rst(rst), .bcd_in(bcd_in),
        .seg(seg_a), .an(an_a), .frame_done(fd_a)
    );

    bcd_display_mux #(.REFRESH_DIV(2), .DIV_W(2), .BLANK_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .bcd_in(bcd_in),
        .seg(seg_b), .an(an_b), .frame_done(fd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [11:0] actual, input logic [11:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Called right after a frame boundary; checks one full 24-cycle frame of dut_a.
    task automatic applyStimulus(input string tag,
                                 input logic [2:0] u_an, input logic [6:0] u_seg,
                                 input logic [2:0] t_an, input logic [6:0] t_seg,
                                 input logic [2:0] h_an, input logic [6:0] h_seg,
                                 input logic [11:0] next_bcd, input int change_at);
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (n == change_at) bcd_in = next_bcd;
            case (n)
                2, 10, 18: begin
                    checkOutput($sformatf("%s n=%0d gap an", tag, n), {9'd0, an_a}, 12'h007);
                    checkOutput($sformatf("%s n=%0d gap seg", tag, n), {5'd0, seg_a}, 12'h07F);
                end
                3, 8: begin
                    checkOutput($sformatf("%s n=%0d units an", tag, n), {9'd0, an_a}, {9'd0, u_an});
                    checkOutput($sformatf("%s n=%0d units seg", tag, n), {5'd0, seg_a}, {5'd0, u_seg});
                end
                11, 16: begin
                    checkOutput($sformatf("%s n=%0d tens an", tag, n), {9'd0, an_a}, {9'd0, t_an});
                    checkOutput($sformatf("%s n=%0d tens seg", tag, n), {5'd0, seg_a}, {5'd0, t_seg});
                end
                19, 24: begin
                    checkOutput($sformatf("%s n=%0d hund an", tag, n), {9'd0, an_a}, {9'd0, h_an});
                    checkOutput($sformatf("%s n=%0d hund seg", tag, n), {5'd0, seg_a}, {5'd0, h_seg});
                end
                default: ;
            endcase
            if (n == 23) checkOutput($sformatf("%s pre frame_done", tag), {11'd0, fd_a}, 12'h000);
            if (n == 24) checkOutput($sformatf("%s frame_done", tag), {11'd0, fd_a}, 12'h001);
        end
    endtask

    logic [6:0] fast_seg [3];

    initial begin
        fast_seg = '{7'h78, 7'h19, 7'h30};
        rst    = 1'b0;
        bcd_in = 12'h347;

        repeat (3) begin
            @(negedge clk);
            checkOutput("reset an", {9'd0, an_a}, 12'h007);
            checkOutput("reset seg", {5'd0, seg_a}, 12'h07F);
            checkOutput("reset frame_done", {11'd0, fd_a}, 12'h000);
        end
        rst = 1'b1;

        // First frame shows the cleared shadow; 347 is captured at its end.
        applyStimulus("f0_000", 3'b110, 7'h40,
                      LZB ? 3'b111 : 3'b101, LZB ? 7'h7F : 7'h40,
                      LZB ? 3'b111 : 3'b011, LZB ? 7'h7F : 7'h40,
                      12'h347, 0);
        applyStimulus("f1_347", 3'b110, 7'h78, 3'b101, 7'h19, 3'b011, 7'h30, 12'h128, 12);
        applyStimulus("f2_128", 3'b110, 7'h00, 3'b101, 7'h24, 3'b011, 7'h79, 12'h0A5, 1);
        applyStimulus("f3_0A5", 3'b110, 7'h12, 3'b101, 7'h3F,
                      LZB ? 3'b111 : 3'b011, LZB ? 7'h7F : 7'h40,
                      12'h007, 1);
        applyStimulus("f4_007", 3'b110, 7'h78,
                      LZB ? 3'b111 : 3'b101, LZB ? 7'h7F : 7'h40,
                      LZB ? 3'b111 : 3'b011, LZB ? 7'h7F : 7'h40,
                      12'h000, 1);
        applyStimulus("f5_000", 3'b110, 7'h40,
                      LZB ? 3'b111 : 3'b101, LZB ? 7'h7F : 7'h40,
                      LZB ? 3'b111 : 3'b011, LZB ? 7'h7F : 7'h40,
                      12'h105, 1);
        applyStimulus("f6_105", 3'b110, 7'h12, 3'b101, 7'h40, 3'b011, 7'h79, 12'h105, 0);

        // Asynchronous reset in the middle of a units slot.
        repeat (4) @(negedge clk);
        checkOutput("mid units an", {9'd0, an_a}, 12'h006);
        #2 rst = 1'b0;
        #1;
        checkOutput("async reset an", {9'd0, an_a}, 12'h007);
        checkOutput("async reset seg", {5'd0, seg_a}, 12'h07F);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus("f7_after_rst", 3'b110, 7'h40,
                      LZB ? 3'b111 : 3'b101, LZB ? 7'h7F : 7'h40,
                      LZB ? 3'b111 : 3'b011, LZB ? 7'h7F : 7'h40,
                      12'h105, 0);

        // Fast instance: 2-cycle slots with no gap.
        rst = 1'b0;
        @(negedge clk);
        checkOutput("fast reset an", {9'd0, an_b}, 12'h007);
        bcd_in = 12'h347;
        rst    = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            int dig;
            @(negedge clk);
            dig = ((n - 1) / 2) % 3;
            checkOutput($sformatf("fast n=%0d an", n), {9'd0, an_b}, {9'd0, ~(3'b001 << dig)});
            checkOutput($sformatf("fast n=%0d seg", n), {5'd0, seg_b},
                        {5'd0, (n <= 6) ? ((LZB && dig != 0) ? 7'h7F : 7'h40) : fast_seg[dig]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
- Downstream consumer of the 3-digit BCD counter's 12-bit output (sal): drives a time-multiplexed, common-anode 3-digit 7-segment display.
- Captures the BCD word once per scan frame so a digit never shows a torn value.
- Scans units, tens, hundreds in turn, with a programmable anode-off gap between slots to suppress ghosting.
- Invalid BCD nibbles show a dash.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot; must be >= 2.
- DIV_W, 16, width of the slot prescaler; must hold REFRESH_DIV-1.
- BLANK_CYC, 4, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV; 0 = no gap.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- bcd_in  in  12  {hundreds[11:8], tens[7:4], units[3:0]}, connects to the counter's sal.
- seg  out  7  {g,f,e,d,c,b,a}, active-low, registered.
- an  out  3  digit anodes, active-low, registered; an[0]=units, an[1]=tens, an[2]=hundreds.
- frame_done  out  1  one-cycle pulse, registered, asserted when a new frame's data is captured.

Behaviour:
- Reset (rst=0, async, takes effect immediately):
  - outputs: an=3'b111, seg=7'h7F, frame_done=0.
  - internal state: div_cnt=0, dig_sel=0 (units), shadow=12'h000.
  - The first frame after reset therefore displays 000.
- Prescaler: div_cnt counts 0..REFRESH_DIV-1 and wraps to 0. tick = (div_cnt==REFRESH_DIV-1).
- Slot state machine, dig_sel: UNITS(0) -> TENS(1) -> HUNDREDS(2) -> UNITS, advancing on tick. No other states are reachable; an encoding of 3 returns to UNITS on the next cycle.
- Frame capture: on a tick while dig_sel==HUNDREDS:
  - shadow <= bcd_in, sampled in that same cycle;
  - frame_done=1 on the next cycle.
  - bcd_in changes at any other time have no visible effect until the next capture.
- Output registers, 1-cycle latency from (div_cnt, dig_sel, shadow):
  - If div_cnt < BLANK_CYC: an=3'b111 and seg=7'h7F.
  - Otherwise: an has a single 0 at bit dig_sel, and seg=decode(shadow nibble selected by dig_sel).
- Decode (active-low, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - A..F = 3F (segment g only, i.e. a dash).
- Slot timing: each slot lasts exactly REFRESH_DIV cycles. The anode is active for REFRESH_DIV-BLANK_CYC cycles, delayed one cycle relative to div_cnt. A frame lasts 3*REFRESH_DIV cycles.
- Simultaneous events:
  - A capture and a dig_sel wrap happen in the same cycle. The UNITS slot that follows uses the new shadow.
  - bcd_in changing in the capture cycle: the value present at that edge is taken.
- Reset mid-slot or mid-frame: outputs go off immediately. After release, scanning restarts at UNITS with div_cnt=0 and shadow=0.
- At most one anode is ever active. No combinational path from bcd_in to any output.

Optional Feature:
- Macro: BCD_DISPLAY_MUX_LZB_EN (leading-zero blanking).
- Defined:
  - hundreds slot: an stays 3'b111 and seg 7'h7F when shadow[11:8]==0;
  - tens slot: same, when shadow[11:4]==0;
  - units slot: never blanked.
  - Blanking uses the captured shadow only. Slot timing and frame_done are unchanged.
- Undefined: all three digits are always driven as above.

Test Plan:
- Reset: hold rst=0, toggle clk -> an=111, seg=7F, frame_done=0 throughout. Assert rst=0 asynchronously mid-slot -> an=111 before the next clk edge.
- Scan with REFRESH_DIV=8, BLANK_CYC=2, bcd_in=12'h347 held, after the first frame_done:
  - units: an=110, seg=78;
  - tens: an=101, seg=19;
  - hundreds: an=011, seg=30.
  - Each slot shows 2 off cycles then 6 on cycles; frame_done period = 24 cycles.
- Frame coherence: switch bcd_in 347 -> 128 during the TENS slot -> the rest of that frame shows 4 then 3. The frame after the next frame_done shows 8, 2, 1.
- Invalid nibble: bcd_in=12'h0A5 -> units seg=12, tens seg=3F, hundreds seg=40 (macro undefined).
- LZB with macro defined:
  - 12'h007 -> an never 101 or 011; units seg=78.
  - 12'h000 -> only units shows 40.
  - 12'h105 -> tens shows 40.
  - Same stimulus with the macro undefined -> all three slots active.
- BLANK_CYC=0, REFRESH_DIV=2 -> an changes every 2 cycles, never 111 after the first post-reset output cycle, never two zeros.
